name_stream_arbiter: RTL and testbench

Round-robin controller that shares one name sequence detector between N independent 8-bit ASCII character sources. It grants the detector to one source for a whole word, clears the detector before each word, and forwards letters with an enable strobe. It collects the detector's match output and reports one result per word (source id, hit, length). It sits between the character front-ends and the single detector instance.

---
 rtl/name_pkg.sv | 20 ++
 rtl/rr_pick.sv | 33 +++
 rtl/name_stream_arbiter.sv | 137 +++++++++++++
 tb/tb_name_stream_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/name_pkg.sv
// Shared types and defaults for the name stream arbiter.
package name_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    REPORT
  } state_t;

  localparam int DEF_N       = 4;
  localparam int DEF_MAX_LEN = 16;
  localparam int DEF_DET_LAT = 1;

  localparam logic [7:0] ASCII_NUL = 8'h00;
  localparam logic [7:0] ASCII_A   = 8'h41;
  localparam logic [7:0] ASCII_Z   = 8'h5A;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid index searching from ptr+1 modulo N.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          any
);

  logic [IW-1:0] cand [N];

  // cand[gi] is the index at distance gi+1 after ptr, wrapped into 0..N-1
  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    logic [IW:0] sum;
    assign sum = {1'b0, ptr} + (IW+1)'(gi + 1);
    assign cand[gi] = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
  end

  // Scan farthest to nearest so the closest valid candidate wins.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (valid[cand[k]]) begin
        grant = cand[k];
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/name_stream_arbiter.sv
// Grants a single name detector to one of N character sources per word and
// reports one result (source, hit, length, truncation) per word.
module name_stream_arbiter
  import name_pkg::*;
#(
  parameter  int N       = DEF_N,
  parameter  int MAX_LEN = DEF_MAX_LEN,
  parameter  int DET_LAT = DEF_DET_LAT,
  localparam int IW      = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    src_valid,
  input  logic [8*N-1:0]  src_data,
  input  logic [N-1:0]    src_last,
  output logic [N-1:0]    src_ready,
  output logic            det_clr,
  output logic            det_en,
  output logic [7:0]      det_letter,
  input  logic [7:0]      det_match,
  output logic            res_valid,
  output logic [IW-1:0]   res_src,
  output logic            res_hit,
  output logic [7:0]      res_len,
  output logic            res_trunc
);

  localparam logic [N-1:0] ONE        = {{(N-1){1'b0}}, 1'b1};
  localparam logic [7:0]   MAX_LEN8   = 8'(MAX_LEN);
  localparam logic [2:0]   LAST_DRAIN = 3'(DET_LAT - 1);

  state_t        state_reg;
  logic [IW-1:0] ptr_reg;
  logic [IW-1:0] grant_reg;
  logic [7:0]    len_reg;
  logic          hit_reg;
  logic          trunc_reg;
  logic [2:0]    drain_cnt_reg;

  logic [IW-1:0] pick;
  logic          pick_any;
  logic [7:0]    data_arr [N];
  logic [7:0]    cur_data;
  logic          cur_last;
  logic          accept;
  logic          match_now;
  logic [7:0]    len_next;

  rr_pick #(.N(N)) u_pick (
    .valid (src_valid),
    .ptr   (ptr_reg),
    .grant (pick),
    .any   (pick_any)
  );

  for (genvar gi = 0; gi < N; gi++) begin : g_data
    assign data_arr[gi] = src_data[gi*8 +: 8];
  end

  assign cur_data  = data_arr[grant_reg];
  assign cur_last  = src_last[grant_reg];
  assign accept    = src_valid[grant_reg] & src_ready[grant_reg];
  assign match_now = (det_match != 8'd0);
  assign len_next  = len_reg + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      ptr_reg       <= IW'(N - 1);
      grant_reg     <= '0;
      len_reg       <= 8'd0;
      hit_reg       <= 1'b0;
      trunc_reg     <= 1'b0;
      drain_cnt_reg <= 3'd0;
      src_ready     <= '0;
      det_clr       <= 1'b0;
      det_en        <= 1'b0;
      det_letter    <= ASCII_NUL;
      res_valid     <= 1'b0;
      res_src       <= '0;
      res_hit       <= 1'b0;
      res_len       <= 8'd0;
      res_trunc     <= 1'b0;
    end else begin
      det_clr   <= 1'b0;
      det_en    <= 1'b0;
      res_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pick_any) begin
            grant_reg <= pick;
            det_clr   <= 1'b1;
            state_reg <= CLEAR;
          end
        end
        CLEAR: begin
          len_reg   <= 8'd0;
          hit_reg   <= 1'b0;
          trunc_reg <= 1'b0;
          src_ready <= ONE << grant_reg;
          state_reg <= STREAM;
        end
        STREAM: begin
          if (match_now) hit_reg <= 1'b1;
          if (accept) begin
            det_en     <= 1'b1;
            det_letter <= cur_data;
            len_reg    <= len_next;
            if (cur_last || len_next == MAX_LEN8) begin
              src_ready     <= '0;
              trunc_reg     <= ~cur_last;
              drain_cnt_reg <= 3'd0;
              state_reg     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (match_now) hit_reg <= 1'b1;
          if (drain_cnt_reg == LAST_DRAIN) state_reg <= REPORT;
          else drain_cnt_reg <= drain_cnt_reg + 3'd1;
        end
        REPORT: begin
          // Match for the final letter lands here when the detector needs the full latency.
          res_valid <= 1'b1;
          res_src   <= grant_reg;
          res_hit   <= hit_reg | match_now;
          res_len   <= len_reg;
          res_trunc <= trunc_reg;
          ptr_reg   <= grant_reg;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_name_stream_arbiter.sv
// Self-checking bench: table of word transactions plus hand sequences for
// round-robin order, mid-word reset and a 3-cycle detector latency.
module tb_name_stream_arbiter;

  localparam logic [71:0] NAME = "RITUSHREE";

  logic        clk;
  logic        rst;
  logic [3:0]  src_valid;
  logic [31:0] src_data;
  logic [3:0]  src_last;
  logic [3:0]  src_ready;
  logic        det_clr, det_en;
  logic [7:0]  det_letter, det_match;
  logic        res_valid, res_hit, res_trunc;
  logic [1:0]  res_src;
  logic [7:0]  res_len;

  logic [3:0]  v3, l3, ready3;
  logic [31:0] d3;
  logic        clr3, en3, rv3, rhit3, rtrunc3;
  logic [7:0]  let3, m3, rlen3;
  logic [1:0]  rsrc3;

  name_stream_arbiter #(.N(4), .MAX_LEN(16), .DET_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_data(src_data),
    .src_last(src_last), .src_ready(src_ready), .det_clr(det_clr),
    .det_en(det_en), .det_letter(det_letter), .det_match(det_match),
    .res_valid(res_valid), .res_src(res_src), .res_hit(res_hit),
    .res_len(res_len), .res_trunc(res_trunc)
  );

  name_stream_arbiter #(.N(4), .MAX_LEN(16), .DET_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .src_valid(v3), .src_data(d3),
    .src_last(l3), .src_ready(ready3), .det_clr(clr3),
    .det_en(en3), .det_letter(let3), .det_match(m3),
    .res_valid(rv3), .res_src(rsrc3), .res_hit(rhit3),
    .res_len(rlen3), .res_trunc(rtrunc3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Detector stub with one cycle latency: matches when the last nine letters spell NAME.
  logic [71:0] hist = '0;
  always @(posedge clk) begin
    if (det_clr) hist <= '0;
    else if (det_en) hist <= {hist[63:0], det_letter};
  end
  assign det_match = (hist == NAME) ? 8'h01 : 8'h00;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Per-source letter queues and the driver that presents them.
  logic [7:0] qd [4][256];
  bit         ql [4][256];
  int         qg [4][256];
  int         qh [4];
  int         qt [4];
  int         gapc [4];

  task automatic push_word(input int s, input string w, input int gp0, input int gp1, input int glen);
    for (int k = 0; k < w.len(); k++) begin
      qd[s][qt[s]] = w[k];
      ql[s][qt[s]] = (k == w.len() - 1);
      qg[s][qt[s]] = (k == gp0 || k == gp1) ? glen : 0;
      if (qh[s] == qt[s]) gapc[s] = qg[s][qt[s]];
      qt[s]++;
    end
  endtask

  initial begin
    logic [3:0] acc;
    src_valid = '0;
    src_data  = '0;
    src_last  = '0;
    forever begin
      @(negedge clk);
      acc = src_valid & src_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (acc[i] && !rst) begin
          qh[i]++;
          if (qh[i] < qt[i]) gapc[i] = qg[i][qh[i]];
        end
        if (qh[i] >= qt[i]) begin
          src_valid[i] = 1'b0;
        end else if (gapc[i] > 0) begin
          src_valid[i] = 1'b0;
          gapc[i]--;
        end else begin
          src_valid[i] = 1'b1;
          src_data[8*i +: 8] = qd[i][qh[i]];
          src_last[i] = ql[i][qh[i]];
        end
      end
    end
  end

  // Output monitor
  int         res_cnt = 0, den_cnt = 0, clr_cnt = 0, hold_err = 0;
  int         en3_cnt = 0, clr3_cnt = 0;
  logic [1:0] r_src [64];
  logic       r_hit [64];
  logic [7:0] r_len [64];
  logic       r_trunc [64];
  int         r_cyc [64];
  logic [7:0] den_log [256];
  logic [7:0] last_letter = '0;

  always @(negedge clk) begin
    if (res_valid) begin
      r_src[res_cnt] = res_src; r_hit[res_cnt] = res_hit;
      r_len[res_cnt] = res_len; r_trunc[res_cnt] = res_trunc;
      r_cyc[res_cnt] = cyc;
      $display("result %0d: src=%0d hit=%0d len=%0d trunc=%0d @%0d",
               res_cnt, res_src, res_hit, res_len, res_trunc, cyc);
      res_cnt++;
    end
    if (det_en) begin
      den_log[den_cnt] = det_letter;
      den_cnt++;
    end
    if (det_clr) clr_cnt++;
    if (!rst && !det_en && det_letter != last_letter) hold_err++;
    last_letter = det_letter;
    if (en3) en3_cnt++;
    if (clr3) clr3_cnt++;
  end

  task automatic wait_res(input int target, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (res_cnt >= target) begin ok = 1; break; end
      @(negedge clk); #1;
    end
    check("res_wait", int'(ok), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, int'(src_ready), 0);
    check({tag, "_clr"}, int'(det_clr), 0);
    check({tag, "_en"}, int'(det_en), 0);
    check({tag, "_letter"}, int'(det_letter), 0);
    check({tag, "_rvalid"}, int'(res_valid), 0);
    check({tag, "_rsrc"}, int'(res_src), 0);
    check({tag, "_rhit"}, int'(res_hit), 0);
    check({tag, "_rlen"}, int'(res_len), 0);
    check({tag, "_rtrunc"}, int'(res_trunc), 0);
  endtask

  typedef struct {
    int src; int widx; int gp0; int gp1; int glen; int nres;
    logic h0; logic [7:0] l0; logic t0;
    logic h1; logic [7:0] l1; logic t1;
  } vec_t;

  string words [7];
  vec_t  vt [7];

  task automatic run_vec(input int vi);
    vec_t v;
    int base, cbase, dbase, t, len, mism;
    bit seen;
    v = vt[vi];
    base = res_cnt; cbase = clr_cnt; dbase = den_cnt;
    len = words[v.widx].len();
    push_word(v.src, words[v.widx], v.gp0, v.gp1, v.glen);
    seen = 0; t = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (src_valid[v.src]) begin seen = 1; t = cyc; break; end
    end
    check("start", int'(seen), 1);
    wait_res(base + v.nres, 300);
    repeat (3) @(negedge clk);
    #1;
    check("res_count", res_cnt - base, v.nres);
    check("src0", int'(r_src[base]), v.src);
    check("hit0", int'(r_hit[base]), int'(v.h0));
    check("len0", int'(r_len[base]), int'(v.l0));
    check("trunc0", int'(r_trunc[base]), int'(v.t0));
    if (v.nres == 2) begin
      check("src1", int'(r_src[base+1]), v.src);
      check("hit1", int'(r_hit[base+1]), int'(v.h1));
      check("len1", int'(r_len[base+1]), int'(v.l1));
      check("trunc1", int'(r_trunc[base+1]), int'(v.t1));
    end
    if (v.nres == 1 && v.glen == 0)
      check("latency", r_cyc[base] - t, 2 + len + 1 + 1);
    check("clr_pulses", clr_cnt - cbase, v.nres);
    check("en_pulses", den_cnt - dbase, len);
    mism = 0;
    for (int k = 0; k < len; k++)
      if (den_log[dbase + k] != words[v.widx][k]) mism++;
    check("letters", mism, 0);
    $display("vector %0d: src=%0d word=%s results=%0d", vi, v.src, words[v.widx], res_cnt - base);
  endtask

  task automatic run3(input bit pulse);
    int t, ebase, cbase;
    bit ok;
    ebase = en3_cnt; cbase = clr3_cnt;
    @(posedge clk); #1;
    t = cyc;
    v3 = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      d3 = {24'd0, 8'h41 + 8'(k)};
      l3 = {3'b000, k == 2};
      ok = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (ready3 == 4'b0001) begin ok = 1; break; end
      end
      check("lat3_ready", int'(ok), 1);
      @(posedge clk); #1;
    end
    v3 = '0; l3 = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    if (pulse) m3 = 8'h05;
    @(posedge clk); #1;
    m3 = 8'h00;
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rv3) begin ok = 1; break; end
    end
    check("lat3_res", int'(ok), 1);
    check("lat3_latency", cyc - t, 2 + 3 + 3 + 1);
    check("lat3_src", int'(rsrc3), 0);
    check("lat3_hit", int'(rhit3), int'(pulse));
    check("lat3_len", int'(rlen3), 3);
    check("lat3_trunc", int'(rtrunc3), 0);
    check("lat3_en", en3_cnt - ebase, 3);
    check("lat3_clr", clr3_cnt - cbase, 1);
    check("lat3_hold", int'(let3), 8'h43);
    $display("lat3 run pulse=%0d: hit=%0d len=%0d", pulse, rhit3, rlen3);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bit ok;
    words[0] = "RITUSHREE";
    words[1] = "aeRITUSHREEgk";
    words[2] = "ABCDEFGHIJKLMNOPQRST";
    words[3] = "HELLO";
    words[4] = "ABCDEFGHIJKLMNOP";
    words[5] = "Z";
    words[6] = "AB";
    vt[0] = '{0, 0, -1, -1, 0, 1, 1'b1, 8'd9,  1'b0, 1'b0, 8'd0, 1'b0};
    vt[1] = '{2, 1,  5,  7, 2, 1, 1'b1, 8'd13, 1'b0, 1'b0, 8'd0, 1'b0};
    vt[2] = '{0, 2, -1, -1, 0, 2, 1'b0, 8'd16, 1'b1, 1'b0, 8'd4, 1'b0};
    vt[3] = '{3, 3, -1, -1, 0, 1, 1'b0, 8'd5,  1'b0, 1'b0, 8'd0, 1'b0};
    vt[4] = '{1, 4, -1, -1, 0, 1, 1'b0, 8'd16, 1'b0, 1'b0, 8'd0, 1'b0};
    vt[5] = '{1, 5, -1, -1, 0, 1, 1'b0, 8'd1,  1'b0, 1'b0, 8'd0, 1'b0};
    vt[6] = '{0, 6, -1, -1, 0, 1, 1'b0, 8'd2,  1'b0, 1'b0, 8'd0, 1'b0};

    rst = 1'b1;
    v3 = '0; d3 = '0; l3 = '0; m3 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    #2 rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(i);

    // Round robin: ptr is 0 after the last vector, so 1 then 3 alternate.
    base = res_cnt;
    push_word(1, "AA", -1, -1, 0);
    push_word(1, "BB", -1, -1, 0);
    push_word(3, "CC", -1, -1, 0);
    push_word(3, "DD", -1, -1, 0);
    wait_res(base + 4, 200);
    for (int j = 0; j < 4; j++) begin
      check("rr_src", int'(r_src[base + j]), (j % 2 == 0) ? 1 : 3);
      check("rr_len", int'(r_len[base + j]), 2);
    end
    $display("round robin: %0d results", res_cnt - base);
    repeat (3) @(negedge clk);

    // Reset while the fifth letter is offered.
    base = res_cnt;
    push_word(0, "RITUSHREE", -1, -1, 0);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (det_clr) begin ok = 1; break; end
    end
    check("rst_clr_seen", int'(ok), 1);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    check_reset_outputs("midrst");
    check("midrst_nores", res_cnt - base, 0);
    qh[0] = qt[0];
    push_word(0, "RITUSHREE", -1, -1, 0);
    rst = 1'b0;
    wait_res(base + 1, 100);
    repeat (3) @(negedge clk);
    check("midrst_count", res_cnt - base, 1);
    check("midrst_src", int'(r_src[base]), 0);
    check("midrst_hit", int'(r_hit[base]), 1);
    check("midrst_len", int'(r_len[base]), 9);
    check("midrst_trunc", int'(r_trunc[base]), 0);
    $display("mid-word reset: resent word len=%0d hit=%0d", r_len[base], r_hit[base]);

    run3(1'b0);
    run3(1'b1);

    check("letter_hold", hold_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
